// File: rtl/isp_wb.sv
// isp_wb: white-balance gain stage of the raw ISP pipeline.
//
// Applies a per-Bayer-channel unsigned Q2.6 gain to every black-corrected
// pixel, rounds half-up, saturates to BITS, and accumulates per-channel
// pre-gain sums over each frame for the AWB firmware loop.
//
// Ports
//   clk              pixel clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   gain_r/gr/gb/b   Q2.6 gains (64 = 1.0x); shadowed, applied per frame
//   per_raw_data     input pixel
//   per_raw_data_en  input pixel valid
//   post_raw_data    gained pixel (holds through enable gaps)
//   post_raw_data_en output pixel valid, input enable delayed 3 cycles
//   stat_sum_*       pre-gain sums of the last completed frame
//   stat_valid       one-cycle pulse when stat_sum_* are updated
//
// Handshake: valid-only stream. A pixel transfers on every rising edge where
// per_raw_data_en=1; there is no ready/backpressure. post_raw_data_en marks
// the cycles in which post_raw_data carries a new pixel.
//
// Bayer channel = {v_cnt[0], h_cnt[0]}: 00 Gb, 01 B, 10 R, 11 Gr.

module isp_wb #(
    parameter int BITS      = 8,
    parameter int WIDTH     = 1936,
    parameter int HEIGHT    = 1088,
    parameter int STAT_BITS = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           gain_r,
    input  logic [7:0]           gain_gr,
    input  logic [7:0]           gain_gb,
    input  logic [7:0]           gain_b,
    input  logic [BITS-1:0]      per_raw_data,
    input  logic                 per_raw_data_en,
    output logic [BITS-1:0]      post_raw_data,
    output logic                 post_raw_data_en,
    output logic [STAT_BITS-1:0] stat_sum_r,
    output logic [STAT_BITS-1:0] stat_sum_gr,
    output logic [STAT_BITS-1:0] stat_sum_gb,
    output logic [STAT_BITS-1:0] stat_sum_b,
    output logic                 stat_valid
);

    localparam int HW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = BITS + 8;          // product width
    localparam int YW = PW - 5;            // width of (p + 32) >> 6
    localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'((1 << BITS) - 1);

    // ---------------- position counters ----------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    chan;
    logic          frame_end;

    assign chan      = {v_cnt[0], h_cnt[0]};
    assign frame_end = per_raw_data_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (per_raw_data_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // ---------------- gain shadow registers ----------------
    // Ports are tracked during reset, then sampled only on the edge that
    // accepts the last pixel of a frame, so a frame always sees one gain set.
    logic [7:0] act_r, act_gr, act_gb, act_b;

    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            act_r  <= gain_r;
            act_gr <= gain_gr;
            act_gb <= gain_gb;
            act_b  <= gain_b;
        end
    end

    logic [7:0] sel_gain;

    always_comb begin
        sel_gain = act_gb;
        case (chan)
            2'b00:   sel_gain = act_gb;
            2'b01:   sel_gain = act_b;
            2'b10:   sel_gain = act_r;
            default: sel_gain = act_gr;
        endcase
    end

    // ---------------- datapath ----------------
    logic            s1_valid, s2_valid;
    logic [BITS-1:0] s1_pix;
    logic [7:0]      s1_gain;
    logic [PW-1:0]   s2_prod;
    logic [PW:0]     rnd;
    logic [YW-1:0]   y;

    assign rnd = {1'b0, s2_prod} + (PW+1)'(32);
    assign y   = rnd[PW:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s2_valid         <= 1'b0;
            post_raw_data_en <= 1'b0;
            s1_pix           <= '0;
            s1_gain          <= '0;
            s2_prod          <= '0;
            post_raw_data    <= '0;
        end else begin
            s1_valid         <= per_raw_data_en;
            s2_valid         <= s1_valid;
            post_raw_data_en <= s2_valid;
            if (per_raw_data_en) begin
                s1_pix  <= per_raw_data;
                s1_gain <= sel_gain;
            end
            if (s1_valid) begin
                s2_prod <= PW'(s1_pix) * PW'(s1_gain);
            end
            if (s2_valid) begin
                post_raw_data <= (y > Y_MAX) ? {BITS{1'b1}} : y[BITS-1:0];
            end
        end
    end

    // ---------------- statistics ----------------
    // acc index follows the channel code: 0 Gb, 1 B, 2 R, 3 Gr.
    logic [STAT_BITS-1:0] acc [4];
    logic [STAT_BITS-1:0] pix_ext;
    logic [STAT_BITS-1:0] add [4];

    assign pix_ext = STAT_BITS'(per_raw_data);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            add[i] = (per_raw_data_en && chan == 2'(i)) ? pix_ext : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            stat_sum_gb <= '0;
            stat_sum_b  <= '0;
            stat_sum_r  <= '0;
            stat_sum_gr <= '0;
            stat_valid  <= 1'b0;
        end else begin
            stat_valid <= frame_end;
            if (frame_end) begin
                // The last pixel is folded straight into the published sum.
                stat_sum_gb <= acc[0] + add[0];
                stat_sum_b  <= acc[1] + add[1];
                stat_sum_r  <= acc[2] + add[2];
                stat_sum_gr <= acc[3] + add[3];
                for (int i = 0; i < 4; i++) acc[i] <= '0;
            end else begin
                for (int i = 0; i < 4; i++) acc[i] <= acc[i] + add[i];
            end
        end
    end

endmodule

// File: tb/tb_isp_wb.sv
// Testbench for isp_wb with a reduced 4x2 frame (8 pixels per frame).
// Frame order: (0,0)Gb (1,0)B (2,0)Gb (3,0)B (0,1)R (1,1)Gr (2,1)R (3,1)Gr.

module tb_isp_wb;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int SB = 28;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    gain_r, gain_gr, gain_gb, gain_b;
    logic [7:0]    per_raw_data;
    logic          per_raw_data_en;
    logic [7:0]    post_raw_data;
    logic          post_raw_data_en;
    logic [SB-1:0] stat_sum_r, stat_sum_gr, stat_sum_gb, stat_sum_b;
    logic          stat_valid;

    always #5 clk = ~clk;

    isp_wb #(.BITS(8), .WIDTH(W), .HEIGHT(H), .STAT_BITS(SB)) dut (
        .clk              (clk),
        .rst              (rst),
        .gain_r           (gain_r),
        .gain_gr          (gain_gr),
        .gain_gb          (gain_gb),
        .gain_b           (gain_b),
        .per_raw_data     (per_raw_data),
        .per_raw_data_en  (per_raw_data_en),
        .post_raw_data    (post_raw_data),
        .post_raw_data_en (post_raw_data_en),
        .stat_sum_r       (stat_sum_r),
        .stat_sum_gr      (stat_sum_gr),
        .stat_sum_gb      (stat_sum_gb),
        .stat_sum_b       (stat_sum_b),
        .stat_valid       (stat_valid)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [SB-1:0] gb;
        logic [SB-1:0] b;
        logic [SB-1:0] r;
        logic [SB-1:0] gr;
    } stat_t;

    logic [7:0] exp_q[$];
    stat_t      stat_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan_of(input int h, input int v);
        return (v % 2) * 2 + (h % 2);
    endfunction

    function automatic stat_t mk_stat(input logic [SB-1:0] a0, input logic [SB-1:0] a1,
                                      input logic [SB-1:0] a2, input logic [SB-1:0] a3,
                                      input logic [7:0] pix, input int ch);
        stat_t s;
        s.gb = a0 + ((ch == 0) ? SB'(pix) : '0);
        s.b  = a1 + ((ch == 1) ? SB'(pix) : '0);
        s.r  = a2 + ((ch == 2) ? SB'(pix) : '0);
        s.gr = a3 + ((ch == 3) ? SB'(pix) : '0);
        return s;
    endfunction

    // Reference model for position, enable delay and frame statistics.
    logic [2:0]    en_pipe  = '0;
    logic          stat_due = 1'b0;
    int            mh = 0, mv = 0;
    logic [SB-1:0] macc [4];

    initial begin
        for (int i = 0; i < 4; i++) macc[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mh = 0; mv = 0; stat_due = 1'b0; en_pipe = '0;
                for (int i = 0; i < 4; i++) macc[i] = '0;
            end else begin
                en_pipe  = {en_pipe[1:0], per_raw_data_en};
                stat_due = 1'b0;
                if (per_raw_data_en) begin
                    if (mh == W - 1 && mv == H - 1) begin
                        stat_q.push_back(mk_stat(macc[0], macc[1], macc[2], macc[3],
                                                 per_raw_data, chan_of(mh, mv)));
                        for (int i = 0; i < 4; i++) macc[i] = '0;
                        stat_due = 1'b1;
                        mh = 0; mv = 0;
                    end else begin
                        macc[chan_of(mh, mv)] = macc[chan_of(mh, mv)] + SB'(per_raw_data);
                        if (mh == W - 1) begin mh = 0; mv = mv + 1; end
                        else mh = mh + 1;
                    end
                end
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("post_en", 32'(post_raw_data_en), 32'(en_pipe[2]));
            if (post_raw_data_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL post_extra: got pixel %0d expected none at %0t", post_raw_data, $time);
                end else begin
                    check("post_data", 32'(post_raw_data), 32'(exp_q[0]));
                    exp_q.delete(0);
                end
            end
            check("stat_valid", 32'(stat_valid), 32'(stat_due));
            if (stat_valid && stat_q.size() != 0) begin
                check("stat_gb", 32'(stat_sum_gb), 32'(stat_q[0].gb));
                check("stat_b",  32'(stat_sum_b),  32'(stat_q[0].b));
                check("stat_r",  32'(stat_sum_r),  32'(stat_q[0].r));
                check("stat_gr", 32'(stat_sum_gr), 32'(stat_q[0].gr));
                stat_q.delete(0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] pix, input logic [7:0] exp);
        @(posedge clk); #1;
        per_raw_data    = pix;
        per_raw_data_en = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            per_raw_data_en = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [7:0] r, input logic [7:0] gr,
                            input logic [7:0] gb, input logic [7:0] b);
        @(posedge clk); #1;
        gain_r = r; gain_gr = gr; gain_gb = gb; gain_b = b;
        rst = 1'b1; per_raw_data_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    // One 4x2 frame of a constant pixel at unity gain, optional random gaps.
    task automatic const_frame(input logic [7:0] pix, input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive(pix, pix);
        end
    endtask

    task automatic check_sums(input string tag, input int v);
        check({tag, "_r"},  32'(stat_sum_r),  v);
        check({tag, "_gr"}, 32'(stat_sum_gr), v);
        check({tag, "_gb"}, 32'(stat_sum_gb), v);
        check({tag, "_b"},  32'(stat_sum_b),  v);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] pix;
        logic [7:0] exp;
        logic [7:0] g_r, g_gr, g_gb, g_b;
        int         gap;
    } vec_t;

    vec_t tbl [24];

    task automatic fill_table();
        // Frame A: active gains r=128 gr=64 gb=64 b=96; ports change gb/b to 32 mid-frame
        tbl[0]  = '{8'd50,  8'd50,  8'd128, 8'd64,  8'd64, 8'd96, 0};
        tbl[1]  = '{8'd3,   8'd5,   8'd128, 8'd64,  8'd64, 8'd96, 1};
        tbl[2]  = '{8'd255, 8'd255, 8'd128, 8'd64,  8'd32, 8'd32, 0};
        tbl[3]  = '{8'd1,   8'd2,   8'd128, 8'd64,  8'd32, 8'd32, 2};
        tbl[4]  = '{8'd100, 8'd200, 8'd128, 8'd64,  8'd32, 8'd32, 0};
        tbl[5]  = '{8'd200, 8'd200, 8'd128, 8'd64,  8'd32, 8'd32, 0};
        tbl[6]  = '{8'd200, 8'd255, 8'd128, 8'd64,  8'd32, 8'd32, 1};
        tbl[7]  = '{8'd7,   8'd7,   8'd128, 8'd64,  8'd32, 8'd32, 0};
        // Frame B (back-to-back): r=128 gr=64 gb=32 b=32; ports change r=0 gr=255 mid-frame
        tbl[8]  = '{8'd50,  8'd25,  8'd128, 8'd64,  8'd32, 8'd32, 0};
        tbl[9]  = '{8'd1,   8'd1,   8'd128, 8'd64,  8'd32, 8'd32, 0};
        tbl[10] = '{8'd255, 8'd128, 8'd0,   8'd255, 8'd32, 8'd32, 1};
        tbl[11] = '{8'd3,   8'd2,   8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[12] = '{8'd100, 8'd200, 8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[13] = '{8'd200, 8'd200, 8'd0,   8'd255, 8'd32, 8'd32, 2};
        tbl[14] = '{8'd1,   8'd2,   8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[15] = '{8'd9,   8'd9,   8'd0,   8'd255, 8'd32, 8'd32, 0};
        // Frame C: r=0 gr=255 gb=32 b=32
        tbl[16] = '{8'd64,  8'd32,  8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[17] = '{8'd2,   8'd1,   8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[18] = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd32, 8'd32, 1};
        tbl[19] = '{8'd255, 8'd128, 8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[20] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[21] = '{8'd255, 8'd255, 8'd0,   8'd255, 8'd32, 8'd32, 0};
        tbl[22] = '{8'd1,   8'd0,   8'd0,   8'd255, 8'd32, 8'd32, 2};
        tbl[23] = '{8'd1,   8'd4,   8'd0,   8'd255, 8'd32, 8'd32, 0};
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        per_raw_data = '0; per_raw_data_en = 1'b0;
        gain_r = 8'd64; gain_gr = 8'd64; gain_gb = 8'd64; gain_b = 8'd64;
        fill_table();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_post", 32'(post_raw_data), 0);
        check_sums("rst_sum", 0);

        // Unity gain ramp: output equals input delayed 3 cycles
        for (int i = 0; i < 256; i++) drive(8'(i), 8'(i));
        idle(4);

        // Channel map, rounding, saturation, gain shadowing, back-to-back frames
        do_reset(8'd128, 8'd64, 8'd64, 8'd96);
        for (int i = 0; i < 24; i++) begin
            idle(tbl[i].gap);
            @(posedge clk); #1;
            gain_r = tbl[i].g_r; gain_gr = tbl[i].g_gr;
            gain_gb = tbl[i].g_gb; gain_b = tbl[i].g_b;
            per_raw_data = tbl[i].pix;
            per_raw_data_en = 1'b1;
            exp_q.push_back(tbl[i].exp);
        end
        idle(4);

        // Statistics with random enable gaps
        do_reset(8'd64, 8'd64, 8'd64, 8'd64);
        const_frame(8'd10, 1'b1);
        idle(3);
        check_sums("sum10", 20);
        const_frame(8'd5, 1'b1);
        idle(3);
        check_sums("sum5", 10);

        // Reset mid-frame at pixel (2,0): in-flight pixels discarded
        drive(8'd10, 8'd10);
        drive(8'd10, 8'd10);
        @(posedge clk); #1;
        rst = 1'b1; per_raw_data = 8'd10; per_raw_data_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; per_raw_data_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_post", 32'(post_raw_data), 0);
        check("midrst_en", 32'(post_raw_data_en), 0);
        check_sums("midrst_sum", 0);
        const_frame(8'd10, 1'b0);
        idle(3);
        check_sums("after_rst", 20);

        idle(4);
        check("exp_q_left", 32'(exp_q.size()), 0);
        check("stat_q_left", 32'(stat_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
